note_recorder: RTL and testbench
================================

NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 Parameter TICK_LIMIT, default 27'd9200000, CLOCK_50 cycles per recorded line minus one.
REQ-002 Parameter MAX_LINES, default 10'd252, highest RAM address written; legal range 0..1023.
REQ-003 Parameter HYST, default 32'd50000000, signed hysteresis threshold for zero-crossing detection.
REQ-004 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 audio_in_available  in  1  audio controller has a sample pair ready.
REQ-007 left_channel_audio_in  in  32  signed sample, two's complement.
REQ-008 read_audio_in  out  1  consume-sample strobe to audio controller.
REQ-009 start  in  1  single-cycle pulse that arms a recording.
REQ-010 stop  in  1  single-cycle pulse that ends a recording early.
REQ-011 ram_address  out  10  note-RAM write address.
REQ-012 ram_data  out  20  half-period delay value for the note RAM.
REQ-013 ram_wren  out  1  one-cycle RAM write enable.
REQ-014 busy  out  1  high in ARM and RECORD.
REQ-015 done  out  1  high in DONE.
REQ-016 lines_written  out  11  count of RAM lines written by the current or last recording.

Function
REQ-017 read_audio_in SHALL equal audio_in_available combinationally in every state, so the input FIFO never stalls.
REQ-018 A sample counts as consumed only when audio_in_available and read_audio_in are both high.
REQ-019 Polarity register pos: on a consumed sample > HYST with pos=0, set pos=1 and flag a crossing; on a sample < -HYST with pos=1, clear pos and flag a crossing; otherwise no crossing.
REQ-020 half_cnt (20 bit) increments every cycle and saturates at 20'hFFFFF; on a crossing it is cleared and its pre-clear value is loaded into last_half.
REQ-021 The crossing also sets valid; valid clears when half_cnt reaches 20'hFFFFF.
REQ-022 last_half therefore uses the playback delay convention: toggle period = value+1 cycles.
REQ-023 FSM states: IDLE, ARM, RECORD, DONE.
REQ-024 IDLE/DONE + start -> ARM: clear ram_address, tick counter, and lines_written; clear done.
REQ-025 ARM + crossing -> RECORD with tick counter at 0.
REQ-026 In RECORD, the tick counter counts 0..TICK_LIMIT; at TICK_LIMIT it SHALL pulse ram_wren for exactly one cycle, with ram_data = valid ? last_half : 20'd0, increment lines_written, and reload the tick counter to 0.
REQ-027 After the write, if ram_address == MAX_LINES -> DONE; otherwise ram_address increments by 1.
REQ-028 ARM or RECORD + stop -> DONE with no further write; a stop in the same cycle as a tick write lets the write complete first.
REQ-029 start is ignored in ARM and RECORD; stop is ignored in IDLE and DONE.
REQ-030 A crossing coincident with a tick write SHALL NOT affect that write, which uses the registered last_half.
REQ-031 ram_address, ram_data and ram_wren are registered outputs; the write occurs one cycle after the tick-counter compare.

Reset
REQ-032 On reset: state=IDLE; pos, valid, half_cnt, last_half, tick counter, ram_address, ram_data, ram_wren, busy, done, and lines_written all 0.
REQ-033 A reset in any state, including mid-write, SHALL abort with no ram_wren in the following cycle.

Configuration
REQ-034 Macro NOTE_RECORDER_SMOOTH_EN: when defined, ram_data = (last_half + prev_half) >> 1 using a 21-bit sum, where prev_half is the prior measurement; if either value is invalid, ram_data = 0.
REQ-035 When NOTE_RECORDER_SMOOTH_EN is undefined, ram_data = last_half per REQ-026, and no prev_half register exists.

Verification (bench: TICK_LIMIT=99, MAX_LINES=3, HYST=1000)
REQ-036 Reset asserted 3 cycles with random inputs -> all outputs 0 and state IDLE.
REQ-037 start, then samples of +5000/-5000 that swap sign every 50 cycles -> first write ram_data=49 at address 0.
REQ-038 start with all samples 0 -> remains in ARM, busy=1, no ram_wren over 10000 cycles.
REQ-039 Full run with a 50-cycle tone -> 4 writes at addresses 0,1,2,3 spaced 100 cycles apart, then done=1 and lines_written=4.
REQ-040 stop after the 2nd write -> DONE, lines_written=2, no further ram_wren; stop in the same cycle as the 3rd tick -> lines_written=3.
REQ-041 Tone ends mid-RECORD and 2^20-1 cycles elapse -> subsequent writes carry ram_data=0; with NOTE_RECORDER_SMOOTH_EN, alternating 49/99 half-periods -> ram_data=74.

Source files
------------

// File: rtl/note_recorder.sv
// Zero-crossing note recorder: measures half-periods of a signed audio stream and writes one
// delay value per tick into the note RAM. Define NOTE_RECORDER_SMOOTH_EN to average consecutive half-periods.
module note_recorder #(
    parameter logic [26:0]        TICK_LIMIT = 27'd9200000,
    parameter logic [9:0]         MAX_LINES  = 10'd252,
    parameter logic signed [31:0] HYST       = 32'sd50000000,
    parameter logic [19:0]        HALF_MAX   = 20'hFFFFF
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    output logic        read_audio_in,
    input  logic        start,
    input  logic        stop,
    output logic [9:0]  ram_address,
    output logic [19:0] ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done,
    output logic [10:0] lines_written
);

    typedef enum logic [1:0] {IDLE, ARM, RECORD, DONE} state_t;

    state_t             state;
    logic signed [31:0] sample;
    logic               consumed;
    logic               crossing;
    logic               pos;
    logic               valid;
    logic [19:0]        half_cnt;
    logic [19:0]        last_half;
    logic [26:0]        tick;
    logic               final_write;
    logic [19:0]        wr_value;

    assign read_audio_in = audio_in_available;
    assign sample        = left_channel_audio_in;
    assign consumed      = audio_in_available & read_audio_in;
    assign crossing      = consumed && ((!pos && (sample > HYST)) || (pos && (sample < -HYST)));
    assign final_write   = ram_wren && (ram_address == MAX_LINES);

`ifdef NOTE_RECORDER_SMOOTH_EN
    logic [19:0] prev_half;
    logic        prev_valid;

    function automatic logic [19:0] smooth_avg(input logic [19:0] a, input logic [19:0] b);
        logic [20:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[20:1];
    endfunction

    assign wr_value = (valid && prev_valid) ? smooth_avg(last_half, prev_half) : 20'd0;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prev_half  <= 20'd0;
            prev_valid <= 1'b0;
        end else if (crossing) begin
            prev_half  <= last_half;
            prev_valid <= valid;
        end else if (half_cnt == HALF_MAX) begin
            prev_valid <= 1'b0;
        end
    end
`else
    assign wr_value = valid ? last_half : 20'd0;
`endif

    // Half-period measurement: value is cycles-between-crossings minus one
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pos       <= 1'b0;
            valid     <= 1'b0;
            half_cnt  <= 20'd0;
            last_half <= 20'd0;
        end else if (crossing) begin
            pos       <= !pos;
            valid     <= 1'b1;
            half_cnt  <= 20'd0;
            last_half <= half_cnt;
        end else if (half_cnt != HALF_MAX) begin
            half_cnt <= half_cnt + 20'd1;
        end else begin
            valid <= 1'b0;
        end
    end

    // Recording FSM; the address advances in the cycle the write is visible
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= IDLE;
            tick          <= 27'd0;
            ram_address   <= 10'd0;
            ram_data      <= 20'd0;
            ram_wren      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_written <= 11'd0;
        end else begin
            ram_wren <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= ARM;
                        tick          <= 27'd0;
                        ram_address   <= 10'd0;
                        lines_written <= 11'd0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                    end
                end
                ARM: begin
                    if (stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (crossing) begin
                        state <= RECORD;
                        tick  <= 27'd0;
                    end
                end
                RECORD: begin
                    if (ram_wren && !final_write)
                        ram_address <= ram_address + 10'd1;
                    if (tick == TICK_LIMIT) begin
                        tick <= 27'd0;
                        if (!final_write) begin
                            ram_wren      <= 1'b1;
                            ram_data      <= wr_value;
                            lines_written <= lines_written + 11'd1;
                        end
                    end else begin
                        tick <= tick + 27'd1;
                    end
                    if (final_write || stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: scenario table for full recordings plus hand-written
// sequences for reset, silent arming, measurement timeout and reset at a write.
module tb_note_recorder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        audio_in_available = 1'b0;
    logic [31:0] left_channel_audio_in = 32'd0;
    logic        read_audio_in;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [9:0]  ram_address;
    logic [19:0] ram_data;
    logic        ram_wren;
    logic        busy;
    logic        done;
    logic [10:0] lines_written;

    always #5 clk = ~clk;

    note_recorder #(
        .TICK_LIMIT(27'd99),
        .MAX_LINES (10'd3),
        .HYST      (32'sd1000),
        .HALF_MAX  (20'd150)
    ) dut (
        .CLOCK_50             (clk),
        .reset                (reset),
        .audio_in_available   (audio_in_available),
        .left_channel_audio_in(left_channel_audio_in),
        .read_audio_in        (read_audio_in),
        .start                (start),
        .stop                 (stop),
        .ram_address          (ram_address),
        .ram_data             (ram_data),
        .ram_wren             (ram_wren),
        .busy                 (busy),
        .done                 (done),
        .lines_written        (lines_written)
    );

    typedef struct {
        int hp_a;
        int hp_b;
        int stop_kind;   // 0 none, 1 stop after 2nd write, 2 stop on 3rd tick
        int exp_lines;
        int d0;
        int d1;
    } row_t;

    row_t rows[5];

    int total = 0;
    int passed = 0;
    int n = 0;
    int mode = 0;        // 0 silence, 1 tone, 2 random
    int hp_a = 50;
    int hp_b = 50;
    int seg_cnt = 0;
    int cur_len = 50;
    bit phase = 1'b0;
    bit level = 1'b0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check2(input string name, input longint act, input longint e0, input longint e1);
        total++;
        if (act == e0 || act == e1) passed++;
        else $display("FAIL %s: got %0d, expected %0d or %0d", name, act, e0, e1);
    endtask

    // One clock: observe outputs at the falling edge, then drive the next inputs
    task automatic cycle(input bit st, input bit sp, input bit rs);
        @(negedge clk);
        if (ram_wren === 1'b1) begin
            wr_addr.push_back(int'(ram_address));
            wr_data.push_back(int'(ram_data));
            wr_cyc.push_back(n);
        end
        start = st;
        stop  = sp;
        reset = rs;
        if (mode == 1) begin
            audio_in_available    = 1'b1;
            left_channel_audio_in = level ? 32'sd5000 : -32'sd5000;
            seg_cnt++;
            if (seg_cnt == cur_len) begin
                seg_cnt = 0;
                level   = !level;
                phase   = !phase;
                cur_len = phase ? hp_b : hp_a;
            end
        end else if (mode == 2) begin
            audio_in_available    = 1'($urandom_range(0, 1));
            left_channel_audio_in = $urandom;
        end else begin
            audio_in_available    = 1'b1;
            left_channel_audio_in = 32'd0;
        end
        n++;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic start_tone(input int a, input int b);
        hp_a = a; hp_b = b; cur_len = a; phase = 1'b0; level = 1'b0; seg_cnt = 0; mode = 1;
    endtask

    task automatic do_reset();
        mode = 0;
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        clear_log();
    endtask

    task automatic warm_and_start(input int a, input int b);
        do_reset();
        start_tone(a, b);
        repeat (300) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_writes(input string name, input int k, input int budget);
        for (int t = 0; t < budget && wr_addr.size() < k; t++) cycle(1'b0, 1'b0, 1'b0);
        check(name, wr_addr.size(), k);
    endtask

    initial begin
        int stop_call, restart_call, prev_size, last_obs, m;

        rows[0] = '{50, 50, 0, 4, 49, 49};
        rows[1] = '{30, 30, 0, 4, 29, 29};
        rows[2] = '{50, 50, 1, 2, 49, 49};
        rows[3] = '{50, 50, 2, 3, 49, 49};
`ifdef NOTE_RECORDER_SMOOTH_EN
        rows[4] = '{50, 100, 0, 4, 74, 74};
`else
        rows[4] = '{50, 100, 0, 4, 49, 99};
`endif

        // Reset with random inputs
        mode = 2;
        repeat (3) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("rst ram_wren", ram_wren, 0);
        check("rst ram_address", ram_address, 0);
        check("rst ram_data", ram_data, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst lines_written", lines_written, 0);
        mode = 0;
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            audio_in_available = 1'(i == 1 || i == 2);
            #1;
            check("read_audio_in follows available", read_audio_in, i == 1 || i == 2);
        end

        // stop ignored in IDLE
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("idle stop done", done, 0);
        check("idle stop busy", busy, 0);

        // Silent input: stays armed, never writes
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (10000) cycle(1'b0, 1'b0, 1'b0);
        check("silent busy", busy, 1);
        check("silent done", done, 0);
        check("silent writes", wr_addr.size(), 0);

        // Scenario table
        for (int r = 0; r < 5; r++) begin
            warm_and_start(rows[r].hp_a, rows[r].hp_b);
            stop_call = -1; restart_call = -1; prev_size = 0;
            for (int t = 0; t < 2000 && done !== 1'b1; t++) begin
                cycle(1'(n == restart_call), 1'(n == stop_call), 1'b0);
                if (wr_addr.size() != prev_size) begin
                    prev_size = wr_addr.size();
                    last_obs  = n - 1;
                    if (prev_size == 2 && rows[r].stop_kind == 1) stop_call = last_obs + 5;
                    if (prev_size == 2 && rows[r].stop_kind == 2) stop_call = last_obs + 99;
                    if (prev_size == 1 && rows[r].stop_kind == 0) restart_call = last_obs + 20;
                end
            end
            check($sformatf("row%0d reached done", r), done, 1);
            repeat (300) cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("row%0d write count", r), wr_addr.size(), rows[r].exp_lines);
            check($sformatf("row%0d lines_written", r), lines_written, rows[r].exp_lines);
            check($sformatf("row%0d done", r), done, 1);
            check($sformatf("row%0d busy", r), busy, 0);
            for (int k = 0; k < wr_addr.size(); k++) begin
                check($sformatf("row%0d addr[%0d]", r, k), wr_addr[k], k);
                check2($sformatf("row%0d data[%0d]", r, k), wr_data[k], rows[r].d0, rows[r].d1);
                if (k > 0) check($sformatf("row%0d spacing[%0d]", r, k), wr_cyc[k] - wr_cyc[k-1], 100);
            end
        end

        // Tone ends mid-recording: measurement expires, later writes carry zero
        warm_and_start(50, 50);
        wait_writes("timeout first write", 1, 500);
        mode = 0;
        for (int t = 0; t < 1000 && done !== 1'b1; t++) cycle(1'b0, 1'b0, 1'b0);
        check("timeout write count", wr_addr.size(), 4);
        if (wr_addr.size() == 4) begin
            check("timeout data[0]", wr_data[0], 49);
            check("timeout data[1]", wr_data[1], 49);
            check("timeout data[2]", wr_data[2], 0);
            check("timeout data[3]", wr_data[3], 0);
        end

        // Reset on the tick compare edge suppresses the pending write
        warm_and_start(50, 50);
        wait_writes("rstwr first write", 1, 500);
        m = wr_cyc.size() > 0 ? wr_cyc[0] : n;
        while (n < m + 99) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("rstwr ram_wren", ram_wren, 0);
        check("rstwr lines_written", lines_written, 0);
        check("rstwr busy", busy, 0);
        repeat (200) cycle(1'b0, 1'b0, 1'b0);
        check("rstwr write count", wr_addr.size(), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
